// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way grant arbiter.
package arb_pkg;
    localparam int ARB_N    = 8;
    localparam int ARB_ID_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/grant_arbiter8_ps8.sv
// ps8: 8-input fixed-priority selector, bit 7 highest; output is one-hot or zero.
module ps8 (
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o
);
    always_comb begin
        gnt_o = '0;
        // Ascending scan so the highest set index is the last one written.
        for (int i = 0; i < 8; i++) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/grant_arbiter8.sv
// grant_arbiter8: non-preemptive 8-way arbiter with zero-bubble handover.
// Define GRANT_ARBITER8_RR_EN for round-robin priority; default is fixed priority (bit 7 highest).
module grant_arbiter8
    import arb_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ARB_N-1:0]    req,
    input  logic                en,
    input  logic                ack,
    output logic [ARB_N-1:0]    gnt,
    output logic [ARB_ID_W-1:0] gnt_id,
    output logic                busy,
    output logic                req_pending
);
    arb_state_t          state_q, state_d;
    logic [ARB_N-1:0]    gnt_q, gnt_d;
    logic [ARB_ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ARB_N-1:0]    masked_req, sel_req, sel_gnt, winner;
    logic                owner_req;

    function automatic logic [ARB_ID_W-1:0] onehot_to_id(input logic [ARB_N-1:0] oh);
        logic [ARB_ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < ARB_N; i++) begin
            if (oh[i]) id = id | ARB_ID_W'(i);
        end
        return id;
    endfunction

    // The owner's bit is masked so a release always hands over to someone else.
    assign masked_req = req & ~gnt_q;
    assign owner_req  = |(req & gnt_q);

`ifdef GRANT_ARBITER8_RR_EN
    logic [ARB_ID_W-1:0] ptr_q, ptr_d;

    // Rotate right by ptr so index ptr-1 lands on bit 7, the selector's top priority.
    function automatic logic [ARB_N-1:0] rot_right(input logic [ARB_N-1:0] v,
                                                   input logic [ARB_ID_W-1:0] s);
        logic [ARB_N-1:0]    r;
        logic [ARB_ID_W-1:0] idx;
        for (int k = 0; k < ARB_N; k++) begin
            idx  = ARB_ID_W'(k) + s;
            r[k] = v[idx];
        end
        return r;
    endfunction

    function automatic logic [ARB_N-1:0] rot_left(input logic [ARB_N-1:0] v,
                                                  input logic [ARB_ID_W-1:0] s);
        logic [ARB_N-1:0]    r;
        logic [ARB_ID_W-1:0] idx;
        for (int k = 0; k < ARB_N; k++) begin
            idx    = ARB_ID_W'(k) + s;
            r[idx] = v[k];
        end
        return r;
    endfunction

    assign sel_req = rot_right(masked_req, ptr_q);
    assign winner  = rot_left(sel_gnt, ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt_d) ptr_d = gnt_id_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    assign sel_req = masked_req;
    assign winner  = sel_gnt;
`endif

    ps8 u_ps8 (
        .req_i (sel_req),
        .gnt_o (sel_gnt)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (en && |req) begin
                    state_d = GRANT;
                    gnt_d   = winner;
                end else begin
                    gnt_d = '0;
                end
            end
            GRANT: begin
                // ack and a dropped owner request are the same single release.
                if (ack || !owner_req) begin
                    if (en && |masked_req) begin
                        gnt_d = winner;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt_id_d = onehot_to_id(gnt_d);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = (state_q == GRANT);
    assign req_pending = |masked_req;
endmodule

// File: tb/tb_grant_arbiter8.sv
// Directed, table-driven bench for grant_arbiter8 (fixed or round-robin build).
module tb_grant_arbiter8;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic       en;
    logic       ack;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       req_pending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic       ack;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       pend;
    } vec_t;

    vec_t vq[$];

`ifdef GRANT_ARBITER8_RR_EN
    localparam logic [7:0] OWN    = 8'h04;
    localparam logic [2:0] OWN_ID = 3'd2;
    localparam bit         RR     = 1'b1;
`else
    localparam logic [7:0] OWN    = 8'h80;
    localparam logic [2:0] OWN_ID = 3'd7;
    localparam bit         RR     = 1'b0;
`endif

    grant_arbiter8 dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .en          (en),
        .ack         (ack),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .req_pending (req_pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic e, input logic a,
                       input logic [7:0] g, input logic [2:0] id,
                       input logic b, input logic p);
        vec_t v;
        v.req = r; v.en = e; v.ack = a; v.gnt = g; v.id = id; v.busy = b; v.pend = p;
        vq.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] order [9];
        logic [7:0] exp_g;

        //   req      en    ack   gnt      id    busy  pend
        add(8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h24, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        add(8'h24, 1'b1, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            add(8'hA4, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1);
        add(8'hA4, 1'b1, 1'b1, OWN,   OWN_ID, 1'b1, 1'b1);
        add(OWN,   1'b1, 1'b0, OWN,   OWN_ID, 1'b1, 1'b0);
        add(8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h01, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h01, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1);
        add(8'h01, 1'b1, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h03, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1);
        add(8'h03, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b1);
        add(8'h03, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1);

        reset_n = 1'b0; req = 8'h00; en = 1'b0; ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.gnt",  gnt, 8'h00);
        chk("rst.id",   8'(gnt_id), 8'h00);
        chk("rst.busy", 8'(busy), 8'h00);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            req = vq[i].req; en = vq[i].en; ack = vq[i].ack;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d.gnt", i),  gnt, vq[i].gnt);
            chk($sformatf("v%0d.id", i),   8'(gnt_id), 8'(vq[i].id));
            chk($sformatf("v%0d.busy", i), 8'(busy), 8'(vq[i].busy));
            chk($sformatf("v%0d.pend", i), 8'(req_pending), 8'(vq[i].pend));
        end

        // Async reset mid-grant, then regrant once reset is released.
        req = 8'h10; en = 1'b1; ack = 1'b1;
        @(posedge clock);
        #1;
        chk("ar.pre.gnt", gnt, 8'h10);
        en = 1'b0; ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("ar.now.gnt",  gnt, 8'h00);
        chk("ar.now.id",   8'(gnt_id), 8'h00);
        chk("ar.now.busy", 8'(busy), 8'h00);
        chk("ar.now.pend", 8'(req_pending), 8'h01);
        @(posedge clock);
        #1;
        chk("ar.hold.gnt", gnt, 8'h00);
        en = 1'b1;
        #2 reset_n = 1'b1;
        #1;
        chk("ar.rel.gnt", gnt, 8'h00);
        @(posedge clock);
        #1;
        chk("ar.regnt.gnt",  gnt, 8'h10);
        chk("ar.regnt.busy", 8'(busy), 8'h01);

        // All eight requesting with ack every cycle.
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        req = 8'hFF; en = 1'b1; ack = 1'b1;
        for (int n = 0; n < 9; n++) begin
            if (RR) order[n] = 3'(7 - (n % 8));
            else    order[n] = (n % 2 == 0) ? 3'd7 : 3'd6;
        end
        for (int n = 0; n < 9; n++) begin
            @(posedge clock);
            #1;
            exp_g = 8'h00;
            exp_g[order[n]] = 1'b1;
            chk($sformatf("all%0d.gnt", n), gnt, exp_g);
            chk($sformatf("all%0d.id", n),  8'(gnt_id), 8'(order[n]));
            chk($sformatf("all%0d.onehot", n), 8'($countones(gnt)), 8'h01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
